// File: rtl/mem_store_checker_pkg.sv
// Shared types for the data-memory store checker: failure codes, FSM states
// and the width helpers used to size table indices and counters.
package checker_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  typedef enum logic [2:0] {
    NONE         = 3'd0,
    UNEXP_ADDR   = 3'd1,
    BAD_DATA     = 3'd2,
    OUT_OF_ORDER = 3'd3,
    DUPLICATE    = 3'd4,
    TIMEOUT      = 3'd5,
    EMPTY        = 3'd6
  } fail_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  // A single-entry table still needs a one-bit index so ports never collapse to zero width.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cntWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_store_checker_if.sv
// Configuration, CPU store snoop and status bundle of the store checker.
interface mem_store_checker_if
  import checker_pkg::*;
#(
  parameter int N_CHECKS = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  localparam int IDX_W = idxWidth(N_CHECKS);
  localparam int CNT_W = cntWidth(N_CHECKS);

  logic              start;
  logic              ordered;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic [CNT_W-1:0]  cfg_count;
  logic              memwrite;
  logic [ADDR_W-1:0] dataaddr;
  logic [DATA_W-1:0] writedata;

  logic              busy;
  logic              pass;
  logic              fail;
  fail_code_t        fail_code;
  logic [IDX_W-1:0]  fail_idx;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic              hit_pulse;
  logic [CNT_W-1:0]  hit_count;
  logic [31:0]       cycles;

  modport master (
    output start, ordered, cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count,
           memwrite, dataaddr, writedata,
    input  busy, pass, fail, fail_code, fail_idx, fail_addr, fail_data,
           hit_pulse, hit_count, cycles
  );

  modport slave (
    input  start, ordered, cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count,
           memwrite, dataaddr, writedata,
    output busy, pass, fail, fail_code, fail_idx, fail_addr, fail_data,
           hit_pulse, hit_count, cycles
  );

endinterface

// File: rtl/mem_store_checker_match.sv
// Combinational classifier: decides whether one CPU store hits an active table
// entry or which failure it represents, for ordered or unordered runs.
module store_match_unit
  import checker_pkg::*;
#(
  parameter int N_CHECKS = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  localparam int IDX_W   = idxWidth(N_CHECKS),
  localparam int CNT_W   = cntWidth(N_CHECKS)
) (
  input  logic [N_CHECKS-1:0][ADDR_W-1:0] tblAddr_i,
  input  logic [N_CHECKS-1:0][DATA_W-1:0] tblData_i,
  input  logic [N_CHECKS-1:0]             hitFlags_i,
  input  logic [CNT_W-1:0]                count_i,
  input  logic                            ordered_i,
  input  logic [ADDR_W-1:0]               addr_i,
  input  logic [DATA_W-1:0]               data_i,
  output logic                            hit_o,
  output logic [IDX_W-1:0]                hitIdx_o,
  output fail_code_t                      failCode_o,
  output logic [IDX_W-1:0]                failIdx_o
);

  logic [N_CHECKS-1:0] addrEq;
  logic [N_CHECKS-1:0] unhitEq;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    firstUnhitEq;
  logic [IDX_W-1:0]    firstEq;
  logic                anyUnhitEq;
  logic                anyEq;

  // Downward scans leave the lowest matching index selected, so duplicate
  // table addresses are consumed lowest index first. In ordered runs the hits
  // are always a prefix, so the lowest un-hit entry equals hit_count.
  always_comb begin
    addrEq       = '0;
    ptr          = '0;
    firstUnhitEq = '0;
    firstEq      = '0;
    anyUnhitEq   = 1'b0;
    anyEq        = 1'b0;
    for (int i = 0; i < N_CHECKS; i++) begin
      if ((i < int'(count_i)) && (tblAddr_i[i] == addr_i)) addrEq[i] = 1'b1;
    end
    unhitEq = addrEq & ~hitFlags_i;
    for (int i = N_CHECKS - 1; i >= 0; i--) begin
      if (unhitEq[i]) begin
        anyUnhitEq   = 1'b1;
        firstUnhitEq = IDX_W'(i);
      end
      if (addrEq[i]) begin
        anyEq   = 1'b1;
        firstEq = IDX_W'(i);
      end
      if (!hitFlags_i[i]) ptr = IDX_W'(i);
    end
  end

  always_comb begin
    hit_o      = 1'b0;
    hitIdx_o   = '0;
    failCode_o = NONE;
    failIdx_o  = '0;
    if (ordered_i) begin
      if (addrEq[ptr]) begin
        if (tblData_i[ptr] == data_i) begin
          hit_o    = 1'b1;
          hitIdx_o = ptr;
        end else begin
          failCode_o = BAD_DATA;
          failIdx_o  = ptr;
        end
      end else if (anyUnhitEq) begin
        failCode_o = OUT_OF_ORDER;
        failIdx_o  = firstUnhitEq;
      end else if (anyEq) begin
        failCode_o = DUPLICATE;
        failIdx_o  = firstEq;
      end else begin
        failCode_o = UNEXP_ADDR;
      end
    end else begin
      if (anyUnhitEq) begin
        if (tblData_i[firstUnhitEq] == data_i) begin
          hit_o    = 1'b1;
          hitIdx_o = firstUnhitEq;
        end else begin
          failCode_o = BAD_DATA;
          failIdx_o  = firstUnhitEq;
        end
      end else if (anyEq) begin
        failCode_o = DUPLICATE;
        failIdx_o  = firstEq;
      end else begin
        failCode_o = UNEXP_ADDR;
      end
    end
  end

endmodule

// File: rtl/mem_store_checker.sv
// Snoops the CPU data-memory write port and checks the stores against a
// programmable table of expected (address, data) checkpoints.
module mem_store_checker
  import checker_pkg::*;
#(
  parameter int N_CHECKS       = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic               clk,
  input  logic               reset,
  mem_store_checker_if.slave bus
);

  localparam int                IDX_W   = idxWidth(N_CHECKS);
  localparam int                CNT_W   = cntWidth(N_CHECKS);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(N_CHECKS);
  localparam bit                TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0]       TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t                         state_q, state_d;
  logic [N_CHECKS-1:0][ADDR_W-1:0] tblAddr_q;
  logic [N_CHECKS-1:0][DATA_W-1:0] tblData_q;
  logic [N_CHECKS-1:0]            hitFlags_q, hitFlags_d;
  logic                           ordered_q, ordered_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [CNT_W-1:0]               hitCount_q, hitCount_d;
  u32                             cycles_q, cycles_d;
  logic                           pass_q, pass_d;
  logic                           fail_q, fail_d;
  fail_code_t                     failCode_q, failCode_d;
  logic [IDX_W-1:0]               failIdx_q, failIdx_d;
  logic [ADDR_W-1:0]              failAddr_q, failAddr_d;
  logic [DATA_W-1:0]              failData_q, failData_d;
  logic                           hitPulse_q, hitPulse_d;

  logic                           tblWe;
  logic [CNT_W-1:0]               countClamped;
  logic                           matchHit;
  logic [IDX_W-1:0]               matchIdx;
  fail_code_t                     matchCode;
  logic [IDX_W-1:0]               matchFailIdx;

  store_match_unit #(
    .N_CHECKS (N_CHECKS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_match (
    .tblAddr_i  (tblAddr_q),
    .tblData_i  (tblData_q),
    .hitFlags_i (hitFlags_q),
    .count_i    (count_q),
    .ordered_i  (ordered_q),
    .addr_i     (bus.dataaddr),
    .data_i     (bus.writedata),
    .hit_o      (matchHit),
    .hitIdx_o   (matchIdx),
    .failCode_o (matchCode),
    .failIdx_o  (matchFailIdx)
  );

  // The table is frozen while a run is active; a write alongside start still lands first.
  assign tblWe        = bus.cfg_we && (state_q != RUN) && (int'(bus.cfg_idx) < N_CHECKS);
  assign countClamped = (bus.cfg_count > MAX_CNT) ? MAX_CNT : bus.cfg_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      tblAddr_q <= '0;
      tblData_q <= '0;
    end else if (tblWe) begin
      tblAddr_q[bus.cfg_idx] <= bus.cfg_addr;
      tblData_q[bus.cfg_idx] <= bus.cfg_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    hitFlags_d = hitFlags_q;
    ordered_d  = ordered_q;
    count_d    = count_q;
    hitCount_d = hitCount_q;
    cycles_d   = cycles_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    failCode_d = failCode_q;
    failIdx_d  = failIdx_q;
    failAddr_d = failAddr_q;
    failData_d = failData_q;
    hitPulse_d = 1'b0;
    if (bus.start) begin
      hitFlags_d = '0;
      hitCount_d = '0;
      cycles_d   = '0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      failCode_d = NONE;
      failIdx_d  = '0;
      failAddr_d = '0;
      failData_d = '0;
      ordered_d  = bus.ordered;
      count_d    = countClamped;
      if (countClamped == '0) begin
        state_d    = FAIL;
        fail_d     = 1'b1;
        failCode_d = EMPTY;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
      if (bus.memwrite && matchHit) begin
        hitFlags_d[matchIdx] = 1'b1;
        hitCount_d           = hitCount_q + CNT_W'(1);
        hitPulse_d           = 1'b1;
        if (hitCount_d == count_q) begin
          state_d = PASS;
          pass_d  = 1'b1;
        end
      end else if (bus.memwrite) begin
        state_d    = FAIL;
        fail_d     = 1'b1;
        failCode_d = matchCode;
        failIdx_d  = matchFailIdx;
        failAddr_d = bus.dataaddr;
        failData_d = bus.writedata;
      end
      // A completing or failing store on the last cycle takes precedence over the timeout.
      if (TO_EN && (cycles_q == TO_LAST) && (state_d == RUN)) begin
        state_d    = FAIL;
        fail_d     = 1'b1;
        failCode_d = TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hitFlags_q <= '0;
      ordered_q  <= 1'b0;
      count_q    <= '0;
      hitCount_q <= '0;
      cycles_q   <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      failCode_q <= NONE;
      failIdx_q  <= '0;
      failAddr_q <= '0;
      failData_q <= '0;
      hitPulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hitFlags_q <= hitFlags_d;
      ordered_q  <= ordered_d;
      count_q    <= count_d;
      hitCount_q <= hitCount_d;
      cycles_q   <= cycles_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      failCode_q <= failCode_d;
      failIdx_q  <= failIdx_d;
      failAddr_q <= failAddr_d;
      failData_q <= failData_d;
      hitPulse_q <= hitPulse_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.fail_code = failCode_q;
  assign bus.fail_idx  = failIdx_q;
  assign bus.fail_addr = failAddr_q;
  assign bus.fail_data = failData_q;
  assign bus.hit_pulse = hitPulse_q;
  assign bus.hit_count = hitCount_q;
  assign bus.cycles    = cycles_q;

endmodule

// File: tb/tb_mem_store_checker.sv
// Scoreboard bench for mem_store_checker: directed stores push expected hit and
// completion events, and a negedge monitor pops and compares them.
module tb_mem_store_checker;
  import checker_pkg::*;

  typedef struct {
    bit          isDone;
    int          atCyc;
    bit          expPass;
    bit          expFail;
    logic [2:0]  code;
    int          idx;
    logic [31:0] addr;
    logic [31:0] data;
    int          hc;
    int          cycVal;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   runStart = 0;
  int   checks = 0;
  int   errors = 0;
  bit   prevDone = 1'b0;
  bit   startSeen = 1'b0;
  exp_t expQ[$];

  mem_store_checker_if #(.N_CHECKS(4), .ADDR_W(32), .DATA_W(32)) bus ();

  mem_store_checker #(
    .N_CHECKS       (4),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushEvent(input bit isDone, input int atCyc, input bit p, input bit f,
                           input logic [2:0] code, input int idx, input logic [31:0] a,
                           input logic [31:0] d, input int hc);
    exp_t e;
    e.isDone  = isDone;
    e.atCyc   = atCyc;
    e.expPass = p;
    e.expFail = f;
    e.code    = code;
    e.idx     = idx;
    e.addr    = a;
    e.data    = d;
    e.hc      = hc;
    e.cycVal  = atCyc - runStart - 1;
    expQ.push_back(e);
  endtask

  task automatic pushHit(input int hc);
    pushEvent(1'b0, cyc + 1, 1'b0, 1'b0, NONE, 0, 0, 0, hc);
  endtask

  task automatic pushPass(input int hc, input int atCyc);
    pushEvent(1'b1, atCyc, 1'b1, 1'b0, NONE, 0, 0, 0, hc);
  endtask

  task automatic pushFail(input fail_code_t code, input int idx, input logic [31:0] a,
                          input logic [31:0] d, input int hc, input int atCyc);
    pushEvent(1'b1, atCyc, 1'b0, 1'b1, code, idx, a, d, hc);
  endtask

  task automatic writeEntry(input int idx, input logic [31:0] a, input logic [31:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 2'(idx);
    bus.cfg_addr = a;
    bus.cfg_data = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic startRun(input int cnt, input bit ord);
    bus.start     = 1'b1;
    bus.ordered   = ord;
    bus.cfg_count = 3'(cnt);
    runStart      = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.dataaddr  = a;
    bus.writedata = d;
    tick();
    bus.memwrite = 1'b0;
  endtask

  task automatic loadTable();
    writeEntry(0, 32'h80, 32'h7);
    writeEntry(1, 32'h84, 32'h7);
    writeEntry(2, 32'h88, 32'h9);
    writeEntry(3, 32'hAC, 32'h33);
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (expQ.size() > 0 && n < maxCycles) begin
      tick();
      n++;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d events outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic handleEvent(input bit isDone);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got %s at cycle %0d, expected none",
               isDone ? "done" : "hit", cyc);
      return;
    end
    e = expQ.pop_front();
    checkOutput("event_kind", 32'(isDone), 32'(e.isDone));
    checkOutput("event_cycle", cyc, e.atCyc);
    checkOutput("hit_count", 32'(bus.hit_count), e.hc);
    if (isDone && e.isDone) begin
      checkOutput("pass", 32'(bus.pass), 32'(e.expPass));
      checkOutput("fail", 32'(bus.fail), 32'(e.expFail));
      checkOutput("fail_code", 32'(bus.fail_code), 32'(e.code));
      checkOutput("fail_idx", 32'(bus.fail_idx), e.idx);
      checkOutput("fail_addr", bus.fail_addr, e.addr);
      checkOutput("fail_data", bus.fail_data, e.data);
      checkOutput("cycles", bus.cycles, e.cycVal);
      checkOutput("busy_done", 32'(bus.busy), 32'd0);
    end
  endtask

  // A completion is a rising pass/fail, or pass/fail right after a start (EMPTY re-arm).
  always @(negedge clk) begin
    bit doneNow;
    doneNow = ((bus.pass === 1'b1) || (bus.fail === 1'b1)) && (!prevDone || startSeen);
    if (bus.hit_pulse === 1'b1) handleEvent(1'b0);
    if (doneNow) handleEvent(1'b1);
    prevDone  = (bus.pass === 1'b1) || (bus.fail === 1'b1);
    startSeen = (bus.start === 1'b1);
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.ordered   = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.cfg_count = '0;
    bus.memwrite  = 1'b0;
    bus.dataaddr  = '0;
    bus.writedata = '0;
    repeat (2) tick();
    reset = 1'b0;

    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_pass", 32'(bus.pass), 32'd0);
    checkOutput("rst_fail", 32'(bus.fail), 32'd0);
    checkOutput("rst_code", 32'(bus.fail_code), 32'd0);
    checkOutput("rst_hit_count", 32'(bus.hit_count), 32'd0);
    checkOutput("rst_cycles", bus.cycles, 32'd0);
    checkOutput("rst_hit_pulse", 32'(bus.hit_pulse), 32'd0);

    loadTable();

    // Ordered pass
    startRun(3, 1'b1);
    checkOutput("run_busy", 32'(bus.busy), 32'd1);
    pushHit(1); applyStimulus(32'h80, 32'h7);
    pushHit(2); applyStimulus(32'h84, 32'h7);
    pushHit(3); pushPass(3, cyc + 1); applyStimulus(32'h88, 32'h9);
    waitDrain(10);

    // Bad data, then a later store must be ignored
    startRun(3, 1'b1);
    pushHit(1); applyStimulus(32'h80, 32'h7);
    pushFail(BAD_DATA, 1, 32'h84, 32'h5, 1, cyc + 1); applyStimulus(32'h84, 32'h5);
    waitDrain(10);
    applyStimulus(32'h88, 32'h9);
    tick();
    checkOutput("held_code", 32'(bus.fail_code), 32'(BAD_DATA));
    checkOutput("held_hit_count", 32'(bus.hit_count), 32'd1);
    checkOutput("held_fail_addr", bus.fail_addr, 32'h84);

    // Out of order, then the same sequence unordered
    startRun(3, 1'b1);
    pushFail(OUT_OF_ORDER, 1, 32'h84, 32'h7, 0, cyc + 1); applyStimulus(32'h84, 32'h7);
    waitDrain(10);
    startRun(3, 1'b0);
    pushHit(1); applyStimulus(32'h84, 32'h7);
    pushHit(2); applyStimulus(32'h88, 32'h9);
    pushHit(3); pushPass(3, cyc + 1); applyStimulus(32'h80, 32'h7);
    waitDrain(10);

    // Unexpected address, then duplicate in unordered mode
    startRun(3, 1'b1);
    pushFail(UNEXP_ADDR, 0, 32'h92, 32'h1, 0, cyc + 1); applyStimulus(32'h92, 32'h1);
    waitDrain(10);
    startRun(3, 1'b0);
    pushHit(1); applyStimulus(32'h80, 32'h7);
    pushFail(DUPLICATE, 0, 32'h80, 32'h7, 1, cyc + 1); applyStimulus(32'h80, 32'h7);
    waitDrain(10);

    // Timeout after the 20th RUN cycle
    startRun(3, 1'b1);
    pushHit(1); applyStimulus(32'h80, 32'h7);
    pushFail(TIMEOUT, 0, 32'h0, 32'h0, 1, runStart + 21);
    waitDrain(40);

    // Final hit on the timeout cycle wins
    startRun(2, 1'b1);
    pushHit(1); applyStimulus(32'h80, 32'h7);
    while (cyc < runStart + 20) tick();
    pushHit(2); pushPass(2, cyc + 1); applyStimulus(32'h84, 32'h7);
    waitDrain(10);

    // Failing store on the timeout cycle reports the store's code
    startRun(3, 1'b1);
    while (cyc < runStart + 20) tick();
    pushFail(UNEXP_ADDR, 0, 32'h92, 32'h1, 0, cyc + 1); applyStimulus(32'h92, 32'h1);
    waitDrain(10);

    // Reset mid-run clears status and table
    startRun(3, 1'b1);
    pushHit(1); applyStimulus(32'h80, 32'h7);
    waitDrain(5);
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_rst_hit_count", 32'(bus.hit_count), 32'd0);
    checkOutput("mid_rst_cycles", bus.cycles, 32'd0);
    checkOutput("mid_rst_pass", 32'(bus.pass), 32'd0);
    checkOutput("mid_rst_fail", 32'(bus.fail), 32'd0);
    reset = 1'b0;
    startRun(1, 1'b1);
    pushFail(UNEXP_ADDR, 0, 32'h80, 32'h7, 0, cyc + 1); applyStimulus(32'h80, 32'h7);
    waitDrain(10);

    // Empty run
    startRun(0, 1'b1);
    pushFail(EMPTY, 0, 32'h0, 32'h0, 0, cyc);
    checkOutput("empty_busy", 32'(bus.busy), 32'd0);
    waitDrain(5);

    // Table write during RUN is ignored
    loadTable();
    startRun(2, 1'b1);
    writeEntry(0, 32'hF0, 32'h55);
    pushHit(1); applyStimulus(32'h80, 32'h7);
    pushHit(2); pushPass(2, cyc + 1); applyStimulus(32'h84, 32'h7);
    waitDrain(10);

    // Count clamps to 4; a write alongside start reaches the table first
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 2'd3;
    bus.cfg_addr = 32'hB0;
    bus.cfg_data = 32'h44;
    startRun(7, 1'b1);
    bus.cfg_we = 1'b0;
    pushHit(1); applyStimulus(32'h80, 32'h7);
    pushHit(2); applyStimulus(32'h84, 32'h7);
    pushHit(3); applyStimulus(32'h88, 32'h9);
    pushHit(4); pushPass(4, cyc + 1); applyStimulus(32'hB0, 32'h44);
    waitDrain(10);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
